// File: rtl/request_cnt_pkg.sv
// request_cnt_pkg: state encoding and default constants shared by request_cnt
package request_cnt_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SEND    = 3'd1,
    WAIT_TX = 3'd2,
    RECV    = 3'd3,
    DONE    = 3'd4
  } state_e;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 100000;
endpackage

// File: rtl/rx_edge.sv
// rx_edge: registered rising-edge detector for the rx_ready level
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset, history forced high
//   rx_ready_i : level input
//   rise_o     : high for the cycle where rx_ready_i is 1 and was 0 last cycle
module rx_edge (
  input  logic clk,
  input  logic rst,
  input  logic rx_ready_i,
  output logic rise_o
);
  logic prev_q;
  // history resets high so a level already present at reset is not a new byte
  always_ff @(posedge clk or posedge rst)
    if (rst) prev_q <= 1'b1;
    else prev_q <= rx_ready_i;
  assign rise_o = rx_ready_i & ~prev_q;
endmodule

// File: rtl/request_cnt.sv
// request_cnt: sends a byte count over UART, checks the returned 0,1,2,... sequence
//   clk, reset              : rising-edge clock, asynchronous active-high reset
//   activate                : level request to run one transaction
//   count_in                : number of bytes to request
//   tx_active, tx_done      : transmitter busy level and byte-finished strobe
//   tx_data, tx_start       : byte to transmit and its one-cycle start strobe
//   rx_ready, rx_data       : received byte valid level and value
//   done                    : transaction finished, held until activate drops
//   error, err_count        : mismatch/timeout flag and saturating mismatch count
//   timeout                 : inter-byte timeout abort
// Optional: define REQUEST_CNT_TIMEOUT_EN to enable the TIMEOUT_CYCLES inter-byte timeout.
module request_cnt
  import request_cnt_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       activate,
  input  logic [7:0] count_in,
  output logic       done,
  output logic       error,
  output logic [7:0] err_count,
  output logic       timeout,
  input  logic       tx_active,
  input  logic       tx_done,
  input  logic       rx_ready,
  input  logic [7:0] rx_data,
  output logic [7:0] tx_data,
  output logic       tx_start
);
  state_e     state_q;
  logic [7:0] cnt_q;
  logic [7:0] exp_q;
  logic [7:0] err_count_q;
  logic [7:0] err_count_d;
  logic [7:0] tx_data_q;
  logic       done_q;
  logic       error_q;
  logic       tx_start_q;
  logic       rise;
  logic       mismatch;
  logic       last;
  rx_edge u_rx_edge (
    .clk        (clk),
    .rst        (reset),
    .rx_ready_i (rx_ready),
    .rise_o     (rise)
  );
  assign mismatch    = rx_data != exp_q;
  assign last        = exp_q == cnt_q - 8'd1;
  assign err_count_d = err_count_q == 8'hFF ? 8'hFF : err_count_q + 8'd1;
`ifdef REQUEST_CNT_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer_q;
  logic          timeout_q;
  logic          expired;
  assign expired = timer_q == TW'(TIMEOUT_CYCLES - 1);
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      exp_q       <= 8'd0;
      err_count_q <= 8'd0;
      tx_data_q   <= 8'd0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      tx_start_q  <= 1'b0;
`ifdef REQUEST_CNT_TIMEOUT_EN
      timer_q     <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE:
          if (activate && !rx_ready) begin
            state_q     <= SEND;
            cnt_q       <= count_in;
            exp_q       <= 8'd0;
            err_count_q <= 8'd0;
            error_q     <= 1'b0;
`ifdef REQUEST_CNT_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
          end
        SEND:
          if (!tx_active) begin
            tx_data_q  <= cnt_q;
            tx_start_q <= 1'b1;
            state_q    <= WAIT_TX;
          end
        WAIT_TX:
          if (tx_done) begin
            state_q <= cnt_q == 8'd0 ? DONE : RECV;
            done_q  <= cnt_q == 8'd0;
`ifdef REQUEST_CNT_TIMEOUT_EN
            timer_q <= '0;
`endif
          end
        RECV:
          if (rise) begin
            exp_q <= exp_q + 8'd1;
            if (mismatch) begin
              err_count_q <= err_count_d;
              error_q     <= 1'b1;
            end
            if (last) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
`ifdef REQUEST_CNT_TIMEOUT_EN
            timer_q <= '0;
          end else if (expired) begin
            timeout_q <= 1'b1;
            error_q   <= 1'b1;
            state_q   <= DONE;
            done_q    <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
`endif
          end
        DONE:
          if (!activate && !rx_ready && !tx_active) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
          end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end
  assign done      = done_q;
  assign error     = error_q;
  assign err_count = err_count_q;
  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
endmodule
